// File: rtl/fir_cfg_master_pkg.sv
// Shared widths, register map, FSM encodings and error codes for the fir
// configuration master.
package fir_cfg_master_pkg;

  localparam int ADDR_W   = 12;
  localparam int DATA_W   = 32;
  localparam int TAPE_NUM = 11;
  localparam int IDX_W    = 4;
  localparam int POLL_W   = 20;

  localparam logic [ADDR_W-1:0] LEN_ADDR  = 12'h30;
  localparam logic [ADDR_W-1:0] TAP_BASE  = 12'h00;
  localparam logic [ADDR_W-1:0] CTRL_ADDR = 12'h2c;
  localparam logic [ADDR_W-1:0] STAT_ADDR = 12'h00;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_WR_LEN   = 3'd1;
  localparam logic [2:0] S_WR_TAP   = 3'd2;
  localparam logic [2:0] S_RD_TAP   = 3'd3;
  localparam logic [2:0] S_WR_START = 3'd4;
  localparam logic [2:0] S_POLL     = 3'd5;
  localparam logic [2:0] S_FIN      = 3'd6;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_TAP     = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;

  function automatic logic [ADDR_W-1:0] tap_addr(input logic [IDX_W-1:0] k);
    return TAP_BASE + {{(ADDR_W-IDX_W-2){1'b0}}, k, 2'b00};
  endfunction

endpackage

// File: rtl/fir_cfg_master_if.sv
// AXI-Lite write-address/write-data/read channels (no B channel) between the
// configuration master and the fir slave port.
interface fir_cfg_master_if;
  import fir_cfg_master_pkg::*;

  // A channel beat transfers at the posedge where valid and ready are both high;
  // the sender holds valid, address and data stable until that edge.
  logic              awvalid;
  logic [ADDR_W-1:0] awaddr;
  logic              awready;
  logic              wvalid;
  logic [DATA_W-1:0] wdata;
  logic              wready;
  logic              arvalid;
  logic [ADDR_W-1:0] araddr;
  logic              arready;
  logic              rvalid;
  logic [DATA_W-1:0] rdata;
  logic              rready;

  modport master (
    output awvalid, awaddr, wvalid, wdata, arvalid, araddr, rready,
    input  awready, wready, arready, rvalid, rdata
  );

  modport slave (
    input  awvalid, awaddr, wvalid, wdata, arvalid, araddr, rready,
    output awready, wready, arready, rvalid, rdata
  );
endinterface

// File: rtl/fir_cfg_master_xact.sv
// Single AXI-Lite transaction engine: accepts one read or write request while
// idle and reports completion combinationally on the finishing edge.
module axil_master_xact
  import fir_cfg_master_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic              i_wr,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_busy,
  output logic              o_done,
  output logic [DATA_W-1:0] o_rdata,
  fir_cfg_master_if.master  bus
);

  logic              r_active, r_wr;
  logic              r_aw_done, r_w_done, r_ar_done, r_r_done;
  logic              r_awvalid, r_wvalid, r_arvalid, r_rready;
  logic [ADDR_W-1:0] r_awaddr, r_araddr;
  logic [DATA_W-1:0] r_wdata, r_rdata;
  logic              w_aw_hs, w_w_hs, w_ar_hs, w_r_hs;

  assign w_aw_hs = r_awvalid & bus.awready;
  assign w_w_hs  = r_wvalid  & bus.wready;
  assign w_ar_hs = r_arvalid & bus.arready;
  assign w_r_hs  = r_rready  & bus.rvalid;

  // Each channel may finish on its own edge; the transaction ends once all have.
  assign o_done = r_active & (r_wr ? ((r_aw_done | w_aw_hs) & (r_w_done | w_w_hs))
                                   : ((r_ar_done | w_ar_hs) & (r_r_done | w_r_hs)));
  assign o_busy  = r_active;
  assign o_rdata = w_r_hs ? bus.rdata : r_rdata;

  assign bus.awvalid = r_awvalid;
  assign bus.awaddr  = r_awaddr;
  assign bus.wvalid  = r_wvalid;
  assign bus.wdata   = r_wdata;
  assign bus.arvalid = r_arvalid;
  assign bus.araddr  = r_araddr;
  assign bus.rready  = r_rready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_active  <= 1'b0;
      r_wr      <= 1'b0;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
      r_ar_done <= 1'b0;
      r_r_done  <= 1'b0;
      r_awvalid <= 1'b0;
      r_wvalid  <= 1'b0;
      r_arvalid <= 1'b0;
      r_rready  <= 1'b0;
      r_awaddr  <= '0;
      r_wdata   <= '0;
      r_araddr  <= '0;
      r_rdata   <= '0;
    end else if (!r_active) begin
      if (i_req) begin
        r_active  <= 1'b1;
        r_wr      <= i_wr;
        r_aw_done <= 1'b0;
        r_w_done  <= 1'b0;
        r_ar_done <= 1'b0;
        r_r_done  <= 1'b0;
        if (i_wr) begin
          r_awvalid <= 1'b1;
          r_wvalid  <= 1'b1;
          r_awaddr  <= i_addr;
          r_wdata   <= i_data;
        end else begin
          r_arvalid <= 1'b1;
          r_rready  <= 1'b1;
          r_araddr  <= i_addr;
        end
      end
    end else begin
      if (w_aw_hs) begin
        r_awvalid <= 1'b0;
        r_aw_done <= 1'b1;
      end
      if (w_w_hs) begin
        r_wvalid <= 1'b0;
        r_w_done <= 1'b1;
      end
      if (w_ar_hs) begin
        r_arvalid <= 1'b0;
        r_ar_done <= 1'b1;
      end
      if (w_r_hs) begin
        r_rready <= 1'b0;
        r_r_done <= 1'b1;
        r_rdata  <= bus.rdata;
      end
      if (o_done) r_active <= 1'b0;
    end
  end

endmodule

// File: rtl/fir_cfg_master.sv
// Sequencer that programs length and taps into fir, verifies the taps, starts
// the accelerator and polls for completion, reporting errors.
module fir_cfg_master
  import fir_cfg_master_pkg::*;
#(
  parameter int unsigned pPOLL_MAX = 1000000
) (
  input  logic              axis_clk,
  input  logic              axis_rst,
  input  logic              cfg_start,
  input  logic [DATA_W-1:0] cfg_length,
  output logic [IDX_W-1:0]  coef_idx,
  input  logic [DATA_W-1:0] coef_data,
  fir_cfg_master_if.master  bus,
  output logic              cfg_busy,
  output logic              cfg_done,
  output logic              cfg_err,
  output logic [1:0]        cfg_err_code,
  output logic [IDX_W-1:0]  cfg_err_idx,
  output logic [2:0]        o_dbg_state
);

  localparam logic [POLL_W-1:0] POLL_LIMIT = POLL_W'(pPOLL_MAX);
  localparam logic [IDX_W-1:0]  LAST_TAP   = IDX_W'(TAPE_NUM - 1);

  logic [2:0]        r_state;
  logic [DATA_W-1:0] r_len;
  logic [IDX_W-1:0]  r_k;
  logic [POLL_W-1:0] r_poll_cnt;
  logic              r_err;
  logic [1:0]        r_err_code;
  logic [IDX_W-1:0]  r_err_idx;

  logic              w_req, w_wr, w_x_busy, w_x_done;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_data, w_x_rdata;
  logic [POLL_W-1:0] w_poll_next;
  logic              w_tap_bad, w_stat_ok, w_last_tap;

  always_comb begin
    w_wr   = 1'b0;
    w_addr = '0;
    w_data = '0;
    case (r_state)
      S_WR_LEN:   begin w_wr = 1'b1; w_addr = LEN_ADDR;       w_data = r_len;     end
      S_WR_TAP:   begin w_wr = 1'b1; w_addr = tap_addr(r_k);  w_data = coef_data; end
      S_RD_TAP:   w_addr = tap_addr(r_k);
      S_WR_START: begin w_wr = 1'b1; w_addr = CTRL_ADDR;      w_data = 32'h1;     end
      S_POLL:     w_addr = STAT_ADDR;
      default:    ;
    endcase
  end

  assign w_req = (r_state != S_IDLE) && (r_state != S_FIN) && !w_x_busy;

  axil_master_xact u_xact (
    .clk     (axis_clk),
    .rst     (axis_rst),
    .i_req   (w_req),
    .i_wr    (w_wr),
    .i_addr  (w_addr),
    .i_data  (w_data),
    .o_busy  (w_x_busy),
    .o_done  (w_x_done),
    .o_rdata (w_x_rdata),
    .bus     (bus)
  );

  assign w_last_tap  = (r_k == LAST_TAP);
  assign w_tap_bad   = (w_x_rdata != coef_data);
  assign w_stat_ok   = (w_x_rdata[2:1] == 2'b11);
  assign w_poll_next = (r_poll_cnt == '1) ? r_poll_cnt : r_poll_cnt + 1'b1;

  always_ff @(posedge axis_clk or posedge axis_rst) begin
    if (axis_rst) begin
      r_state    <= S_IDLE;
      r_len      <= '0;
      r_k        <= '0;
      r_poll_cnt <= '0;
      r_err      <= 1'b0;
      r_err_code <= ERR_NONE;
      r_err_idx  <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (cfg_start) begin
          r_len      <= cfg_length;
          r_err      <= 1'b0;
          r_err_code <= ERR_NONE;
          r_err_idx  <= '0;
          r_k        <= '0;
          r_state    <= S_WR_LEN;
        end
        S_WR_LEN: if (w_x_done) r_state <= S_WR_TAP;
        S_WR_TAP: if (w_x_done) begin
          r_k <= w_last_tap ? '0 : r_k + 1'b1;
          if (w_last_tap) r_state <= S_RD_TAP;
        end
        S_RD_TAP: if (w_x_done) begin
          // Only the first mismatch is recorded; remaining taps are still read.
          if (w_tap_bad && r_err_code == ERR_NONE) begin
            r_err_code <= ERR_TAP;
            r_err_idx  <= r_k;
          end
          r_k <= w_last_tap ? '0 : r_k + 1'b1;
          if (w_last_tap)
            r_state <= (w_tap_bad || r_err_code != ERR_NONE) ? S_FIN : S_WR_START;
        end
        S_WR_START: if (w_x_done) begin
          r_poll_cnt <= '0;
          r_state    <= S_POLL;
        end
        S_POLL: if (w_x_done) begin
          r_poll_cnt <= w_poll_next;
          if (w_stat_ok) begin
            r_state <= S_FIN;
          end else if (w_poll_next >= POLL_LIMIT) begin
            r_err_code <= ERR_TIMEOUT;
            r_state    <= S_FIN;
          end
        end
        S_FIN: begin
          r_err   <= (r_err_code != ERR_NONE);
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign coef_idx     = r_k;
  assign cfg_busy     = (r_state != S_IDLE);
  assign cfg_done     = (r_state == S_FIN);
  assign cfg_err      = r_err;
  assign cfg_err_code = r_err_code;
  assign cfg_err_idx  = r_err_idx;
  assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_fir_cfg_master.sv
// Bench for fir_cfg_master: AXI-Lite slave model with configurable ready delays,
// transaction log checked against a sequence built from the register-map rules.
module tb_fir_cfg_master;
  import fir_cfg_master_pkg::*;

  localparam int POLL_MAX = 8;

  logic        clk, rst;
  logic        cfg_start;
  logic [31:0] cfg_length;
  logic [3:0]  coef_idx;
  logic [31:0] coef_data;
  logic        cfg_busy, cfg_done, cfg_err;
  logic [1:0]  cfg_err_code;
  logic [3:0]  cfg_err_idx;
  logic [2:0]  dbg_state;

  fir_cfg_master_if bus ();

  fir_cfg_master #(.pPOLL_MAX(POLL_MAX)) dut (
    .axis_clk     (clk),
    .axis_rst     (rst),
    .cfg_start    (cfg_start),
    .cfg_length   (cfg_length),
    .coef_idx     (coef_idx),
    .coef_data    (coef_data),
    .bus          (bus),
    .cfg_busy     (cfg_busy),
    .cfg_done     (cfg_done),
    .cfg_err      (cfg_err),
    .cfg_err_code (cfg_err_code),
    .cfg_err_idx  (cfg_err_idx),
    .o_dbg_state  (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- coefficient source ----------------
  logic [31:0] taps [0:10];
  assign coef_data = (coef_idx < 4'd11) ? taps[coef_idx] : 32'h0;

  // ---------------- slave model ----------------
  int          aw_dly, w_dly, ar_dly;
  int          poll_done_at;
  int          fault_idx;
  logic [31:0] fault_val;
  logic        clr;

  logic [31:0] mem [0:15];
  logic        ctrl_written;
  int          stat_reads;
  int          viol;
  logic        saw_w_first;
  int          aw_wait, w_wait, ar_wait;
  logic        aw_have, w_have, aw_prev_v, w_prev_v;
  logic [11:0] aw_a, aw_prev_a;
  logic [31:0] w_d, w_prev_d, rd_val;
  logic [44:0] obs_q [$];

  logic        aw_fire, w_fire, ar_fire, a_ok, d_ok;
  logic [11:0] addr_now;
  logic [31:0] data_now;

  assign bus.awready = bus.awvalid && (aw_wait >= aw_dly);
  assign bus.wready  = bus.wvalid  && (w_wait  >= w_dly);
  assign bus.arready = bus.arvalid && (ar_wait >= ar_dly);
  assign bus.rvalid  = bus.arvalid && bus.arready;
  assign bus.rdata   = rd_val;

  assign aw_fire  = bus.awvalid && bus.awready;
  assign w_fire   = bus.wvalid && bus.wready;
  assign ar_fire  = bus.arvalid && bus.arready;
  assign a_ok     = aw_have || aw_fire;
  assign d_ok     = w_have || w_fire;
  assign addr_now = aw_fire ? bus.awaddr : aw_a;
  assign data_now = w_fire ? bus.wdata : w_d;

  always_comb begin
    rd_val = 32'h0;
    if (ctrl_written && bus.araddr == 12'h000) begin
      rd_val = (poll_done_at != 0 && stat_reads + 1 >= poll_done_at) ? 32'h6 : 32'h0;
    end else begin
      rd_val = mem[bus.araddr[5:2]];
      if (int'(bus.araddr[5:2]) == fault_idx) rd_val = fault_val;
    end
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      aw_wait   <= 0;
      w_wait    <= 0;
      ar_wait   <= 0;
      aw_have   <= 1'b0;
      w_have    <= 1'b0;
      aw_prev_v <= 1'b0;
      w_prev_v  <= 1'b0;
    end else begin
      if (clr) begin
        ctrl_written <= 1'b0;
        stat_reads   <= 0;
      end
      aw_prev_v <= bus.awvalid && !bus.awready;
      aw_prev_a <= bus.awaddr;
      w_prev_v  <= bus.wvalid && !bus.wready;
      w_prev_d  <= bus.wdata;
      if (aw_prev_v && (!bus.awvalid || bus.awaddr != aw_prev_a)) viol <= viol + 1;
      if (w_prev_v && (!bus.wvalid || bus.wdata != w_prev_d)) viol <= viol + 1;
      if (aw_fire && aw_have) viol <= viol + 1;
      if (w_fire && w_have) viol <= viol + 1;
      if (ar_fire && !bus.rready) viol <= viol + 1;
      if (w_fire && !a_ok) saw_w_first <= 1'b1;

      if (aw_fire) aw_wait <= 0;
      else if (bus.awvalid) aw_wait <= aw_wait + 1;
      if (w_fire) w_wait <= 0;
      else if (bus.wvalid) w_wait <= w_wait + 1;

      if ((aw_fire || w_fire) && a_ok && d_ok) begin
        obs_q.push_back({1'b1, addr_now, data_now});
        mem[addr_now[5:2]] <= data_now;
        if (addr_now == 12'h02c) ctrl_written <= 1'b1;
        aw_have <= 1'b0;
        w_have  <= 1'b0;
      end else begin
        if (aw_fire) begin aw_have <= 1'b1; aw_a <= bus.awaddr; end
        if (w_fire)  begin w_have  <= 1'b1; w_d  <= bus.wdata;  end
      end

      if (ar_fire) begin
        ar_wait <= 0;
        obs_q.push_back({1'b0, bus.araddr, rd_val});
        if (ctrl_written && bus.araddr == 12'h000) stat_reads <= stat_reads + 1;
      end else if (bus.arvalid) begin
        ar_wait <= ar_wait + 1;
      end
    end
  end

  // ---------------- scoreboard ----------------
  int          n_checks, n_errors;
  logic [44:0] exp_q [$];
  logic [1:0]  exp_code;
  logic [3:0]  exp_idx;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: the bus traffic and outcome the register map rules imply.
  task automatic build_exp(input logic [31:0] len);
    int          first_bad;
    logic [31:0] rb;
    exp_q.delete();
    exp_code = 2'd0;
    exp_idx  = 4'd0;
    first_bad = -1;
    exp_q.push_back({1'b1, 12'h030, len});
    for (int k = 0; k < 11; k++) exp_q.push_back({1'b1, 12'(4 * k), taps[k]});
    for (int k = 0; k < 11; k++) begin
      rb = (k == fault_idx) ? fault_val : taps[k];
      exp_q.push_back({1'b0, 12'(4 * k), rb});
      if (rb != taps[k] && first_bad < 0) first_bad = k;
    end
    if (first_bad >= 0) begin
      exp_code = 2'd1;
      exp_idx  = 4'(first_bad);
    end else begin
      exp_q.push_back({1'b1, 12'h02c, 32'h1});
      for (int n = 1; n <= POLL_MAX; n++) begin
        if (poll_done_at != 0 && n >= poll_done_at) begin
          exp_q.push_back({1'b0, 12'h000, 32'h6});
          break;
        end
        exp_q.push_back({1'b0, 12'h000, 32'h0});
        if (n == POLL_MAX) exp_code = 2'd2;
      end
    end
  endtask

  // ---------------- driver ----------------
  task automatic run(input string name, input logic [31:0] len, input bit chk_timing,
                     input bit spur);
    int base, cyc, busy_cnt, done_cnt, obs_n;
    bit spur_done;
    build_exp(len);
    base = obs_q.size();
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    cfg_start  = 1'b1;
    cfg_length = len;
    @(negedge clk);
    cfg_start = 1'b0;
    cyc = 0; busy_cnt = 0; done_cnt = 0; spur_done = 1'b0;
    while (cyc < 5000) begin
      if (chk_timing && cyc == 0) check({name, "_awvalid_c0"}, 64'(bus.awvalid), 64'd0);
      if (chk_timing && cyc == 1) check({name, "_awvalid_c1"}, 64'(bus.awvalid), 64'd1);
      if (cfg_busy) busy_cnt++;
      if (cfg_done) begin
        done_cnt++;
        check({name, "_busy_at_done"}, 64'(cfg_busy), 64'd1);
      end
      if (!cfg_busy) break;
      cfg_start = 1'b0;
      if (spur && !spur_done && obs_q.size() - base >= 14) begin
        cfg_start  = 1'b1;
        cfg_length = ~len;
        spur_done  = 1'b1;
      end
      @(negedge clk);
      cyc++;
    end
    cfg_start = 1'b0;
    check({name, "_finished"}, 64'(cyc < 5000), 64'd1);
    check({name, "_done_pulses"}, 64'(done_cnt), 64'd1);
    if (chk_timing) check({name, "_busy_cycles"}, 64'(busy_cnt), 64'(2 * exp_q.size() + 1));
    check({name, "_err"}, 64'(cfg_err), 64'(exp_code != 2'd0));
    check({name, "_err_code"}, 64'(cfg_err_code), 64'(exp_code));
    check({name, "_err_idx"}, 64'(cfg_err_idx), 64'(exp_idx));
    obs_n = obs_q.size() - base;
    check({name, "_xact_count"}, 64'(obs_n), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      if (i < obs_n) check($sformatf("%s_xact%0d", name, i), 64'(obs_q[base + i]), 64'(exp_q[i]));
    check({name, "_protocol"}, 64'(viol), 64'd0);
  endtask

  task automatic rand_taps();
    for (int k = 0; k < 11; k++) taps[k] = $urandom;
  endtask

  task automatic check_reset_values(input string name);
    check({name, "_awvalid"}, 64'(bus.awvalid), 64'd0);
    check({name, "_wvalid"},  64'(bus.wvalid),  64'd0);
    check({name, "_arvalid"}, 64'(bus.arvalid), 64'd0);
    check({name, "_rready"},  64'(bus.rready),  64'd0);
    check({name, "_awaddr"},  64'(bus.awaddr),  64'd0);
    check({name, "_wdata"},   64'(bus.wdata),   64'd0);
    check({name, "_araddr"},  64'(bus.araddr),  64'd0);
    check({name, "_coef_idx"}, 64'(coef_idx),   64'd0);
    check({name, "_busy"},    64'(cfg_busy),    64'd0);
    check({name, "_done"},    64'(cfg_done),    64'd0);
    check({name, "_err"},     64'(cfg_err),     64'd0);
    check({name, "_err_code"}, 64'(cfg_err_code), 64'd0);
    check({name, "_err_idx"}, 64'(cfg_err_idx), 64'd0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int wait_cyc;
    n_checks = 0; n_errors = 0;
    viol = 0; saw_w_first = 1'b0; ctrl_written = 1'b0; stat_reads = 0;
    aw_dly = 0; w_dly = 0; ar_dly = 0;
    poll_done_at = 3; fault_idx = -1; fault_val = 32'h0;
    clr = 1'b0; cfg_start = 1'b0; cfg_length = 32'h0;
    for (int i = 0; i < 16; i++) mem[i] = 32'h0;
    taps[0] = 32'd0;  taps[1] = -32'sd10; taps[2] = -32'sd9; taps[3] = 32'd23;
    taps[4] = 32'd56; taps[5] = 32'd63;   taps[6] = 32'd56;  taps[7] = 32'd23;
    taps[8] = -32'sd9; taps[9] = -32'sd10; taps[10] = 32'd0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    rst = 1'b0;
    @(negedge clk);

    // Always-ready slave, status done on the third poll.
    run("basic", 32'd600, 1'b1, 1'b0);

    // awready three cycles late, wready immediate.
    aw_dly = 3;
    run("aw_late", 32'd600, 1'b0, 1'b0);
    check("aw_late_w_first", 64'(saw_w_first), 64'd1);
    aw_dly = 0;

    // Tap 5 reads back corrupted.
    fault_idx = 5; fault_val = 32'd62;
    run("tap_err", 32'd600, 1'b0, 1'b0);
    fault_idx = -1;

    // Status never completes: timeout after POLL_MAX reads.
    poll_done_at = 0;
    run("timeout", 32'd600, 1'b0, 1'b0);
    poll_done_at = 3;

    // Start pulse during tap readback is ignored.
    run("spur_start", 32'd77, 1'b0, 1'b1);
    repeat (4) @(negedge clk);
    check("spur_no_restart", 64'(cfg_busy), 64'd0);

    // Randomized traffic: delays, taps, length, poll completion, optional fault.
    for (int r = 0; r < 4; r++) begin
      rand_taps();
      aw_dly = $urandom_range(0, 3);
      w_dly  = $urandom_range(0, 3);
      ar_dly = $urandom_range(0, 3);
      poll_done_at = $urandom_range(1, 5);
      fault_idx = (r == 2) ? $urandom_range(0, 10) : -1;
      fault_val = taps[(fault_idx < 0) ? 0 : fault_idx] ^ (32'h1 << $urandom_range(0, 31));
      run($sformatf("rand%0d", r), $urandom_range(1, 4096), 1'b0, 1'b0);
    end
    aw_dly = 0; w_dly = 0; ar_dly = 0; fault_idx = -1; poll_done_at = 3;

    // Reset while a write is outstanding.
    aw_dly = 6;
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    cfg_start = 1'b1; cfg_length = 32'd600;
    @(negedge clk);
    cfg_start = 1'b0;
    wait_cyc = 0;
    while (!bus.awvalid && wait_cyc < 20) begin
      @(negedge clk);
      wait_cyc++;
    end
    check("rst_mid_awvalid_seen", 64'(bus.awvalid), 64'd1);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst_mid_awvalid", 64'(bus.awvalid), 64'd0);
    check("rst_mid_wvalid", 64'(bus.wvalid), 64'd0);
    check("rst_mid_busy", 64'(cfg_busy), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    aw_dly = 0;
    @(negedge clk);
    check_reset_values("rst_mid_after");
    rand_taps();
    run("after_rst", 32'd1234, 1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
